// File: rtl/riscv_alu_decode.sv
// riscv_alu_decode: RV64 datapath slice for R-type, ld, sd and beq.
// Main control decode, ALU-control decode, B-operand select and a WORDSIZE-bit
// ALU, with every output captured in a single register stage (1-cycle latency).
module riscv_alu_decode #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [31:0]         instr,
  input  logic [WORDSIZE-1:0] rs1data,
  input  logic [WORDSIZE-1:0] rs2data,
  input  logic [WORDSIZE-1:0] immediate,
  output logic                out_valid,
  output logic                branch,
  output logic                memread,
  output logic                memwrite,
  output logic                memtoreg,
  output logic                alusrc,
  output logic                regwrite,
  output logic [1:0]          aluop,
  output logic [3:0]          alucmd,
  output logic [WORDSIZE-1:0] alures,
  output logic                aluz,
  output logic                take_br
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_OR  = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_XOR = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0110;
  localparam logic [3:0] CMD_SLT = 4'b0111;
  localparam logic [3:0] CMD_NOR = 4'b1100;

  // Combinational decode / ALU nets
  logic                w_branch;
  logic                w_memread;
  logic                w_memwrite;
  logic                w_memtoreg;
  logic                w_alusrc;
  logic                w_regwrite;
  logic [1:0]          w_aluop;
  logic [3:0]          w_alucmd;
  logic [3:0]          w_key;
  logic [WORDSIZE-1:0] w_opb;
  logic [WORDSIZE-1:0] w_alures;
  logic                w_aluz;

  // Output register stage
  logic                r_out_valid;
  logic                r_branch;
  logic                r_memread;
  logic                r_memwrite;
  logic                r_memtoreg;
  logic                r_alusrc;
  logic                r_regwrite;
  logic [1:0]          r_aluop;
  logic [3:0]          r_alucmd;
  logic [WORDSIZE-1:0] r_alures;
  logic                r_aluz;
  logic                r_take_br;

  assign w_key = {instr[30], instr[14:12]};

  // Main control decode from the opcode; unknown opcodes decode to a NOP
  always_comb begin
    w_branch   = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrc   = 1'b0;
    w_regwrite = 1'b0;
    w_aluop    = 2'b00;
    case (instr[6:0])
      OP_RTYPE: begin
        w_regwrite = 1'b1;
        w_aluop    = 2'b10;
      end
      OP_LD: begin
        w_memread  = 1'b1;
        w_memtoreg = 1'b1;
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_SD: begin
        w_memwrite = 1'b1;
        w_alusrc   = 1'b1;
      end
      OP_BEQ: begin
        w_branch = 1'b1;
        w_aluop  = 2'b01;
      end
      default: begin
        w_aluop = 2'b00;
      end
    endcase
  end

  // ALU-control decode: op class plus {funct7[5], funct3} selects the command
  always_comb begin
    w_alucmd = CMD_ADD;
    case (w_aluop)
      2'b00: w_alucmd = CMD_ADD;
      2'b01: w_alucmd = CMD_SUB;
      2'b10: begin
        case (w_key)
          4'b0000: w_alucmd = CMD_ADD;
          4'b1000: w_alucmd = CMD_SUB;
          4'b0111: w_alucmd = CMD_AND;
          4'b0110: w_alucmd = CMD_OR;
          4'b0100: w_alucmd = CMD_XOR;
          4'b0010: w_alucmd = CMD_SLT;
          default: w_alucmd = CMD_ADD;
        endcase
      end
      default: w_alucmd = CMD_ADD;
    endcase
  end

  assign w_opb = w_alusrc ? immediate : rs2data;

  // ALU datapath; add/sub wrap naturally, unassigned command codes yield zero
  always_comb begin
    w_alures = {WORDSIZE{1'b0}};
    case (w_alucmd)
      CMD_AND: w_alures = rs1data & w_opb;
      CMD_OR:  w_alures = rs1data | w_opb;
      CMD_ADD: w_alures = rs1data + w_opb;
      CMD_XOR: w_alures = rs1data ^ w_opb;
      CMD_SUB: w_alures = rs1data - w_opb;
      CMD_SLT: w_alures = ($signed(rs1data) < $signed(w_opb)) ? WORDSIZE'(1) : {WORDSIZE{1'b0}};
      CMD_NOR: w_alures = ~(rs1data | w_opb);
      default: w_alures = {WORDSIZE{1'b0}};
    endcase
  end

  assign w_aluz = (w_alures == {WORDSIZE{1'b0}});

  // Output stage: reset clears everything, valid captures, idle drops controls but holds result/zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_branch    <= 1'b0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_alusrc    <= 1'b0;
      r_regwrite  <= 1'b0;
      r_aluop     <= 2'b00;
      r_alucmd    <= 4'b0000;
      r_alures    <= {WORDSIZE{1'b0}};
      r_aluz      <= 1'b0;
      r_take_br   <= 1'b0;
    end else if (in_valid) begin
      r_out_valid <= 1'b1;
      r_branch    <= w_branch;
      r_memread   <= w_memread;
      r_memwrite  <= w_memwrite;
      r_memtoreg  <= w_memtoreg;
      r_alusrc    <= w_alusrc;
      r_regwrite  <= w_regwrite;
      r_aluop     <= w_aluop;
      r_alucmd    <= w_alucmd;
      r_alures    <= w_alures;
      r_aluz      <= w_aluz;
      r_take_br   <= w_branch & w_aluz;
    end else begin
      r_out_valid <= 1'b0;
      r_branch    <= 1'b0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_alusrc    <= 1'b0;
      r_regwrite  <= 1'b0;
      r_aluop     <= 2'b00;
      r_alucmd    <= 4'b0000;
      r_take_br   <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign branch    = r_branch;
  assign memread   = r_memread;
  assign memwrite  = r_memwrite;
  assign memtoreg  = r_memtoreg;
  assign alusrc    = r_alusrc;
  assign regwrite  = r_regwrite;
  assign aluop     = r_aluop;
  assign alucmd    = r_alucmd;
  assign alures    = r_alures;
  assign aluz      = r_aluz;
  assign take_br   = r_take_br;

endmodule

// File: tb/tb_riscv_alu_decode.sv
// Directed self-checking bench for riscv_alu_decode.
module tb_riscv_alu_decode;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [63:0] rs1data;
  logic [63:0] rs2data;
  logic [63:0] immediate;
  logic        out_valid;
  logic        branch;
  logic        memread;
  logic        memwrite;
  logic        memtoreg;
  logic        alusrc;
  logic        regwrite;
  logic [1:0]  aluop;
  logic [3:0]  alucmd;
  logic [63:0] alures;
  logic        aluz;
  logic        take_br;

  int n_cmp;
  int n_err;

  riscv_alu_decode #(.WORDSIZE(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .instr     (instr),
    .rs1data   (rs1data),
    .rs2data   (rs2data),
    .immediate (immediate),
    .out_valid (out_valid),
    .branch    (branch),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .alusrc    (alusrc),
    .regwrite  (regwrite),
    .aluop     (aluop),
    .alucmd    (alucmd),
    .alures    (alures),
    .aluz      (aluz),
    .take_br   (take_br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word with only the fields the block looks at populated
  function automatic logic [31:0] mk(input logic b30, input logic [2:0] f3, input logic [6:0] op);
    mk = {1'b0, b30, 15'd0, f3, 5'd0, op};
  endfunction

  // Apply one cycle of inputs and sample 1 time unit after the capturing edge
  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
    rst = r; in_valid = v; instr = ins; rs1data = a; rs2data = b; immediate = im;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Control bundle {branch,memread,memwrite,memtoreg,alusrc,regwrite,aluop}
  task automatic chk_all(input string tag, input logic ov, input logic [7:0] ctrl,
                         input logic [3:0] cmd, input logic [63:0] res,
                         input logic z, input logic tb);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
    chk({tag, ".ctrl"}, {56'd0, branch, memread, memwrite, memtoreg, alusrc, regwrite, aluop}, {56'd0, ctrl});
    chk({tag, ".alucmd"}, {60'd0, alucmd}, {60'd0, cmd});
    chk({tag, ".alures"}, alures, res);
    chk({tag, ".aluz"}, {63'd0, aluz}, {63'd0, z});
    chk({tag, ".take_br"}, {63'd0, take_br}, {63'd0, tb});
  endtask

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [7:0] C_R   = 8'b0000_0110;
  localparam logic [7:0] C_LD  = 8'b0101_1100;
  localparam logic [7:0] C_SD  = 8'b0010_1000;
  localparam logic [7:0] C_BEQ = 8'b1000_0001;
  localparam logic [7:0] C_NOP = 8'b0000_0000;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0;
    rs1data = 64'd0; rs2data = 64'd0; immediate = 64'd0;

    // Reset dominates a valid instruction
    step(1'b1, 1'b1, mk(1'b0, 3'b000, OP_R), 64'd5, 64'd7, 64'd0);
    chk_all("reset", 1'b0, C_NOP, 4'b0000, 64'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, mk(1'b0, 3'b000, OP_R), 64'd5, 64'd7, 64'd0);
    chk_all("idle_after_reset", 1'b0, C_NOP, 4'b0000, 64'd0, 1'b0, 1'b0);

    // R-type ALU operations
    step(1'b0, 1'b1, mk(1'b0, 3'b000, OP_R), 64'd5, 64'd7, 64'd0);
    chk_all("add", 1'b1, C_R, 4'b0010, 64'd12, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b1, 3'b000, OP_R), 64'd3, 64'd5, 64'd0);
    chk_all("sub", 1'b1, C_R, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b010, OP_R), 64'd3, 64'd5, 64'd0);
    chk_all("slt_3_5", 1'b1, C_R, 4'b0111, 64'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b010, OP_R), 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
    chk_all("slt_neg", 1'b1, C_R, 4'b0111, 64'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b010, OP_R), 64'd5, 64'd3, 64'd0);
    chk_all("slt_false", 1'b1, C_R, 4'b0111, 64'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b111, OP_R), 64'hF0F0, 64'hFF00, 64'd0);
    chk_all("and", 1'b1, C_R, 4'b0000, 64'hF000, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b110, OP_R), 64'hF0F0, 64'hFF00, 64'd0);
    chk_all("or", 1'b1, C_R, 4'b0001, 64'hFFF0, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b100, OP_R), 64'hF0F0, 64'hFF00, 64'd0);
    chk_all("xor", 1'b1, C_R, 4'b0011, 64'h0FF0, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b001, OP_R), 64'd2, 64'd9, 64'd0);
    chk_all("rtype_other_key", 1'b1, C_R, 4'b0010, 64'd11, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b000, OP_R), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    chk_all("add_wrap", 1'b1, C_R, 4'b0010, 64'd0, 1'b1, 1'b0);

    // Memory ops use the immediate as operand B
    step(1'b0, 1'b1, mk(1'b0, 3'b011, OP_LD), 64'd16, 64'd99, 64'd8);
    chk_all("ld", 1'b1, C_LD, 4'b0010, 64'd24, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b011, OP_SD), 64'd16, 64'd99, 64'hFFFF_FFFF_FFFF_FFF8);
    chk_all("sd", 1'b1, C_SD, 4'b0010, 64'd8, 1'b0, 1'b0);

    // Branches
    step(1'b0, 1'b1, mk(1'b0, 3'b000, OP_BEQ), 64'd42, 64'd42, 64'd0);
    chk_all("beq_taken", 1'b1, C_BEQ, 4'b0110, 64'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, mk(1'b0, 3'b000, OP_BEQ), 64'd42, 64'd41, 64'd0);
    chk_all("beq_not_taken", 1'b1, C_BEQ, 4'b0110, 64'd1, 1'b0, 1'b0);

    // Unknown opcode: NOP controls, add command, B = rs2
    step(1'b0, 1'b1, mk(1'b1, 3'b010, OP_BAD), 64'd1, 64'd2, 64'd100);
    chk_all("unknown_op", 1'b1, C_NOP, 4'b0010, 64'd3, 1'b0, 1'b0);

    // Back-to-back ld / add / beq
    step(1'b0, 1'b1, mk(1'b0, 3'b011, OP_LD), 64'd100, 64'd7, 64'd4);
    chk_all("b2b_ld", 1'b1, C_LD, 4'b0010, 64'd104, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b000, OP_R), 64'd100, 64'd7, 64'd4);
    chk_all("b2b_add", 1'b1, C_R, 4'b0010, 64'd107, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b000, OP_BEQ), 64'd7, 64'd7, 64'd4);
    chk_all("b2b_beq", 1'b1, C_BEQ, 4'b0110, 64'd0, 1'b1, 1'b1);

    // Idle: controls drop, result and zero flag hold
    step(1'b0, 1'b0, mk(1'b0, 3'b000, OP_R), 64'd3, 64'd4, 64'd0);
    chk_all("idle_hold", 1'b0, C_NOP, 4'b0000, 64'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 3'b000, OP_R), 64'd3, 64'd4, 64'd0);
    chk_all("add_after_idle", 1'b1, C_R, 4'b0010, 64'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, mk(1'b0, 3'b000, OP_R), 64'd0, 64'd0, 64'd0);
    chk_all("idle_hold2", 1'b0, C_NOP, 4'b0000, 64'd7, 1'b0, 1'b0);

    // Reset after a zero result clears aluz to 0
    step(1'b0, 1'b1, mk(1'b0, 3'b000, OP_BEQ), 64'd9, 64'd9, 64'd0);
    chk_all("beq_before_rst", 1'b1, C_BEQ, 4'b0110, 64'd0, 1'b1, 1'b1);
    step(1'b1, 1'b1, mk(1'b0, 3'b000, OP_BEQ), 64'd9, 64'd9, 64'd0);
    chk_all("reset_clears_aluz", 1'b0, C_NOP, 4'b0000, 64'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
